ob_stream_tx: RTL

- Outbound card-to-host streamer: reads finished packets from the shared 128-bit packet RAM, serialises each 128-bit word into two 64-bit AXI-Stream beats on the XDMA C2H channel 0, then raises a user interrupt.
- Sits between the packet RAM outbound read port and the XDMA `s_axis_c2h_*_0` / `usr_irq_*` pins.
- It is the transmit counterpart of the inbound H2C receiver that writes the RAM.

---
 rtl/ob_stream_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ob_stream_tx.sv
// Card-to-host streamer: reads finished packets from the packet RAM, splits each
// 128-bit word into two 64-bit C2H AXI-Stream beats, then raises a user interrupt.
module ob_stream_tx #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned SLOT_AW   = 9,
    parameter int unsigned PKT_WORDS = 4,
    parameter int unsigned IRQ_BIT   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SLOTS-1:0]                  data_valid,
    output logic [NUM_SLOTS-1:0]                  slot_release,
    output logic                                  rd_en,
    output logic [$clog2(NUM_SLOTS)+SLOT_AW-1:0]  rd_addr,
    input  logic [127:0]                          rd_data,
    output logic [63:0]                           s_axis_c2h_tdata_0,
    output logic [7:0]                            s_axis_c2h_tkeep_0,
    output logic                                  s_axis_c2h_tlast_0,
    output logic                                  s_axis_c2h_tvalid_0,
    input  logic                                  s_axis_c2h_tready_0,
    output logic [3:0]                            usr_irq_req,
    input  logic [3:0]                            usr_irq_ack,
    input  logic                                  msi_enable
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned WORD_W = SLOT_AW + 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(PKT_WORDS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_LATCH   = 3'd2;
    localparam logic [2:0] S_SEND_LO = 3'd3;
    localparam logic [2:0] S_SEND_HI = 3'd4;
    localparam logic [2:0] S_IRQ     = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [127:0]      data_buf_q, data_buf_d;

    logic              found;
    logic [SLOT_W-1:0] pick;
    logic [SLOT_W-1:0] cand;
    logic              last_word;
    logic              unused_ack;

    assign last_word  = (word_q == LAST_WORD);
    assign unused_ack = ^usr_irq_ack;

    // Round-robin search starting at rr_ptr, wrapping upward.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            cand = rr_ptr_q + i[SLOT_W-1:0];
            if (!found && data_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_slot_d = cur_slot_q;
        word_d     = word_q;
        data_buf_d = data_buf_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    cur_slot_d = pick;
                    word_d     = '0;
                    state_d    = S_READ;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                data_buf_d = rd_data;
                state_d    = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (s_axis_c2h_tready_0) state_d = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (s_axis_c2h_tready_0) begin
                    if (last_word) begin
                        state_d = msi_enable ? S_IRQ : S_RELEASE;
                    end else begin
                        word_d  = word_q + WORD_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_IRQ: begin
                if (usr_irq_ack[IRQ_BIT]) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                rr_ptr_d = cur_slot_q + SLOT_W'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            cur_slot_q <= '0;
            word_q     <= '0;
            data_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_slot_q <= cur_slot_d;
            word_q     <= word_d;
            data_buf_q <= data_buf_d;
        end
    end

    // All outputs decode from registered state only, so tready never reaches tvalid.
    always_comb begin
        rd_en               = (state_q == S_READ);
        rd_addr             = '0;
        s_axis_c2h_tvalid_0 = 1'b0;
        s_axis_c2h_tkeep_0  = '0;
        s_axis_c2h_tdata_0  = '0;
        s_axis_c2h_tlast_0  = 1'b0;
        slot_release        = '0;
        usr_irq_req         = '0;
        case (state_q)
            S_READ: rd_addr = {cur_slot_q, word_q[SLOT_AW-1:0]};
            S_SEND_LO: begin
                s_axis_c2h_tvalid_0 = 1'b1;
                s_axis_c2h_tkeep_0  = '1;
                s_axis_c2h_tdata_0  = data_buf_q[63:0];
            end
            S_SEND_HI: begin
                s_axis_c2h_tvalid_0 = 1'b1;
                s_axis_c2h_tkeep_0  = '1;
                s_axis_c2h_tdata_0  = data_buf_q[127:64];
                s_axis_c2h_tlast_0  = last_word;
            end
            S_IRQ:     usr_irq_req[IRQ_BIT]     = 1'b1;
            S_RELEASE: slot_release[cur_slot_q] = 1'b1;
            default: ;
        endcase
    end

endmodule
